pulse_width_monitor: RTL and testbench
======================================

PULSE_WIDTH_MONITOR -- requirements
Module: pulse_width_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4, number of monitored channels (1..32).
REQ-002 SHALL have parameter CW, default 8, pulse-width counter width in bits.
REQ-003 SHALL have parameter VCW, default 16, global violation counter width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sig_in  input  NCH  monitored signals, already synchronous to clk.
REQ-007 SHALL have port cfg_limit  input  CW  minimum legal pulse width, in cycles.
REQ-008 SHALL have port cfg_thresh  input  CW  glitch threshold; pulses narrower than this are not reported.
REQ-009 SHALL have port cfg_mode  input  2  check select: 00 none, 01 high pulses, 10 low pulses, 11 both.
REQ-010 SHALL have port clr  input  1  clears the sticky flags and the violation counter.
REQ-011 SHALL have port viol_pulse  output  NCH  one-cycle strobe per violating channel.
REQ-012 SHALL have port viol_flag  output  NCH  sticky per-channel notifier.
REQ-013 SHALL have port viol_cnt  output  VCW  saturating total violation count.

Function
REQ-014 Per-channel FSM SHALL have states ARM -> WAIT -> MEAS.
- ARM: capture sig_in as prev; go to WAIT next cycle.
- WAIT: on edge (sig_in != prev), count=1, go to MEAS; the level present before the first edge is never checked.
REQ-015 In MEAS, a cycle with no edge SHALL increment count, saturating at 2^CW-1.
REQ-016 In MEAS, an edge SHALL end the pulse: width W = count, level = prev; count reloads to 1 on the same cycle.
REQ-017 An ended pulse SHALL violate iff its level is enabled by cfg_mode AND cfg_thresh <= W < cfg_limit; config is sampled on the terminating-edge cycle.
REQ-018 cfg_limit=0 SHALL never violate; a saturated count SHALL never violate.
REQ-019 viol_pulse[i] SHALL assert exactly one cycle, in the cycle after the terminating edge is sampled (latency 1).
REQ-020 viol_flag[i] SHALL set together with viol_pulse[i] and hold until clr or rst.
REQ-021 viol_cnt SHALL add the popcount of viol_pulse each cycle and saturate at 2^VCW-1.
REQ-022 clr concurrent with a new violation: flags and counter clear, then the new violations apply (flag=1, cnt=popcount).
REQ-023 cfg_mode=00 SHALL still track widths; no violations are reported.

Reset
REQ-024 rst SHALL put every channel in ARM with count=0 and prev=0, and set viol_pulse=0, viol_flag=0, viol_cnt=0.
REQ-025 rst asserted mid-pulse SHALL abandon that pulse with no violation; rst SHALL take priority over clr.

Structure
REQ-026 Shared package pw_mon_pkg SHALL hold the FSM state encoding (ARM, WAIT, MEAS) and the cfg_mode encodings.
REQ-027 The per-channel FSM and counter SHALL be sub-module pw_mon_chan, instantiated NCH times by a generate loop; the top holds the popcount and viol_cnt.

Verification
REQ-028 Bench SHALL cover: limit=6, thresh=0, mode=01, ch0 high pulse 4 cycles -> viol_pulse[0] one cycle after the falling edge, viol_flag[0]=1, viol_cnt=1.
REQ-029 Bench SHALL cover: same config, high pulse 6 cycles -> no violation; low pulse 2 cycles with mode=01 -> no violation; with mode=10 -> violation.
REQ-030 Bench SHALL cover: limit=6, thresh=3, high pulses of 2 and 3 cycles -> only the 3-cycle pulse is reported.
REQ-031 Bench SHALL cover: 4 channels violate in the same cycle while clr=1 -> viol_flag=4'hF, viol_cnt=4.
REQ-032 Bench SHALL cover: VCW=4, 20 violations -> viol_cnt holds at 15; CW=4 with a pulse of 40 cycles and limit=15 -> no violation.
REQ-033 Bench SHALL cover: rst during a 3-cycle high pulse, limit=6 -> no violation; the first level after reset is not checked.

Source files
------------

// File: rtl/pw_mon_pkg.sv
// Shared definitions for the pulse-width monitor:
// per-channel FSM states and check-mode encodings.
package pw_mon_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEAS = 2'd2
    } chan_state_e;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_HIGH = 2'b01;
    localparam logic [1:0] MODE_LOW  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic level_checked(
        input logic [1:0] mode,
        input logic       level
    );
        logic en;
        case (mode)
            MODE_NONE: en = 1'b0;
            MODE_HIGH: en = level;
            MODE_LOW:  en = !level;
            MODE_BOTH: en = 1'b1;
            default:   en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/pulse_width_monitor_chan.sv
// One monitored channel: edge tracking, width counter
// and the violation decision for each completed pulse.
module pw_mon_chan
    import pw_mon_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig,
    input  logic [CW-1:0] cfg_limit,
    input  logic [CW-1:0] cfg_thresh,
    input  logic [1:0]    cfg_mode,
    output logic          viol_next,
    output logic          viol_pulse
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    chan_state_e   state_q, state_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] count_q, count_d;
    logic          viol_q, viol_d;
    logic          sig_edge;
    logic          bad_width;

    assign sig_edge = sig != prev_q;

    // Saturated widths are unknown-length pulses, never reported.
    assign bad_width = level_checked(cfg_mode, prev_q)
                     && (cfg_limit != '0)
                     && (count_q != CNT_MAX)
                     && (count_q >= cfg_thresh)
                     && (count_q < cfg_limit);

    always_comb begin
        state_d = state_q;
        prev_d  = sig;
        count_d = count_q;
        viol_d  = 1'b0;
        case (state_q)
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sig_edge) begin
                    count_d = CW'(1);
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (sig_edge) begin
                    viol_d  = bad_width;
                    count_d = CW'(1);
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARM;
            prev_q  <= 1'b0;
            count_q <= '0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            viol_q  <= viol_d;
        end
    end

    assign viol_next  = viol_d;
    assign viol_pulse = viol_q;

endmodule

// File: rtl/pulse_width_monitor.sv
// Multi-channel pulse-width monitor: per-channel checkers
// plus sticky flags and a saturating violation total.
module pulse_width_monitor
    import pw_mon_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int VCW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  sig_in,
    input  logic [CW-1:0]   cfg_limit,
    input  logic [CW-1:0]   cfg_thresh,
    input  logic [1:0]      cfg_mode,
    input  logic            clr,
    output logic [NCH-1:0]  viol_pulse,
    output logic [NCH-1:0]  viol_flag,
    output logic [VCW-1:0]  viol_cnt
);

    localparam int SW = VCW + 6;
    localparam logic [VCW-1:0] CNT_MAX = '1;

    logic [NCH-1:0] hit;
    logic [NCH-1:0] flag_q, flag_d;
    logic [VCW-1:0] cnt_q, cnt_d;
    logic [SW-1:0]  pop;
    logic [SW-1:0]  sum;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pw_mon_chan #(
            .CW(CW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .sig        (sig_in[g]),
            .cfg_limit  (cfg_limit),
            .cfg_thresh (cfg_thresh),
            .cfg_mode   (cfg_mode),
            .viol_next  (hit[g]),
            .viol_pulse (viol_pulse[g])
        );
    end

    // Flags and total load on the same edge as the pulse register.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + SW'(hit[i]);
        end
        sum    = (clr ? '0 : {6'b0, cnt_q}) + pop;
        cnt_d  = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[VCW-1:0];
        flag_d = (clr ? '0 : flag_q) | hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign viol_flag = flag_q;
    assign viol_cnt  = cnt_q;

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Bench for pulse_width_monitor: directed table, corner
// sequences and random traffic against a reference model.
module tb_pulse_width_monitor;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic [NCH-1:0] sig_in;
    logic [7:0]     cfg_limit;
    logic [7:0]     cfg_thresh;
    logic [1:0]     cfg_mode;
    logic [NCH-1:0] pulse_a, flag_a, pulse_b, flag_b;
    logic [15:0]    cnt_a;
    logic [3:0]     cnt_b;

    always #5 clk = ~clk;

    pulse_width_monitor #(.NCH(NCH), .CW(8), .VCW(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .cfg_limit  (cfg_limit),
        .cfg_thresh (cfg_thresh),
        .cfg_mode   (cfg_mode),
        .clr        (clr),
        .viol_pulse (pulse_a),
        .viol_flag  (flag_a),
        .viol_cnt   (cnt_a)
    );

    pulse_width_monitor #(.NCH(NCH), .CW(4), .VCW(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .cfg_limit  (cfg_limit[3:0]),
        .cfg_thresh (cfg_thresh[3:0]),
        .cfg_mode   (cfg_mode),
        .clr        (clr),
        .viol_pulse (pulse_b),
        .viol_flag  (flag_b),
        .viol_cnt   (cnt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: sample index since reset, last edge index per channel.
    int             nsamp = 0;
    logic [NCH-1:0] prev_m = '0;
    int             last_edge [NCH];
    int             cnt_m [2];
    logic [NCH-1:0] flag_m [2];
    logic [NCH-1:0] pulse_m [2];

    function automatic int cw_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int vcw_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic bit violates(input int w, input int cw, input int lim,
                                    input int thr, input logic [1:0] mode,
                                    input logic level);
        int maxw;
        int we;
        int l;
        int t;
        bit en;
        maxw = (1 << cw) - 1;
        we   = (w > maxw) ? maxw : w;
        l    = lim & maxw;
        t    = thr & maxw;
        en   = level ? mode[0] : mode[1];
        return en && (l != 0) && (we != maxw) && (we >= t) && (we < l);
    endfunction

    task automatic model_step();
        logic [NCH-1:0] hit [2];
        if (rst) begin
            nsamp  = 0;
            prev_m = '0;
            for (int c = 0; c < NCH; c++) last_edge[c] = -1;
            for (int k = 0; k < 2; k++) begin
                cnt_m[k]   = 0;
                flag_m[k]  = '0;
                pulse_m[k] = '0;
            end
        end else begin
            hit[0] = '0;
            hit[1] = '0;
            for (int c = 0; c < NCH; c++) begin
                if (nsamp > 0 && sig_in[c] != prev_m[c]) begin
                    if (last_edge[c] >= 0) begin
                        for (int k = 0; k < 2; k++) begin
                            hit[k][c] = violates(nsamp - last_edge[c], cw_of(k),
                                                 cfg_limit, cfg_thresh,
                                                 cfg_mode, prev_m[c]);
                        end
                    end
                    last_edge[c] = nsamp;
                end
            end
            prev_m = sig_in;
            nsamp++;
            for (int k = 0; k < 2; k++) begin
                if (clr) begin
                    cnt_m[k]  = 0;
                    flag_m[k] = '0;
                end
                cnt_m[k]   = cnt_m[k] + $countones(hit[k]);
                flag_m[k]  = flag_m[k] | hit[k];
                pulse_m[k] = hit[k];
            end
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic compare_model();
        check("model_pulse_a", pulse_a, pulse_m[0]);
        check("model_flag_a", flag_a, flag_m[0]);
        check("model_cnt_a", cnt_a, sat(cnt_m[0], vcw_of(0)));
        check("model_pulse_b", pulse_b, pulse_m[1]);
        check("model_flag_b", flag_b, flag_m[1]);
        check("model_cnt_b", cnt_b, sat(cnt_m[1], vcw_of(1)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic run(input logic [NCH-1:0] s, input int n);
        sig_in = s;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clr    = 1'b0;
        sig_in = '0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       sig;
        logic [1:0] mode;
        logic       pulse;
        logic       flag;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [1:0] m,
                       input logic p, input logic f, input int c, input int n);
        vec_t v;
        v.rst = r; v.sig = s; v.mode = m;
        v.pulse = p; v.flag = f; v.cnt = c;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        sig_in     = '0;
        cfg_limit  = 8'd6;
        cfg_thresh = 8'd0;
        cfg_mode   = 2'b01;

        // ch0 only: 4-cycle high (viol), 6-cycle high, 2-cycle low in both modes
        add(1, 0, 2'b01, 0, 0, 0, 1);
        add(0, 0, 2'b01, 0, 0, 0, 2);
        add(0, 1, 2'b01, 0, 0, 0, 4);
        add(0, 0, 2'b01, 1, 1, 1, 1);
        add(0, 0, 2'b01, 0, 1, 1, 1);
        add(0, 1, 2'b01, 0, 1, 1, 6);
        add(0, 0, 2'b01, 0, 1, 1, 2);
        add(0, 1, 2'b01, 0, 1, 1, 2);
        add(0, 0, 2'b10, 0, 1, 1, 2);
        add(0, 1, 2'b10, 1, 1, 2, 1);
        add(0, 1, 2'b10, 0, 1, 2, 1);

        foreach (tbl[i]) begin
            rst      = tbl[i].rst;
            sig_in   = {3'b000, tbl[i].sig};
            cfg_mode = tbl[i].mode;
            cycle();
            check($sformatf("tbl%0d_pulse", i), pulse_a, {3'b000, tbl[i].pulse});
            check($sformatf("tbl%0d_flag", i), flag_a, {3'b000, tbl[i].flag});
            check($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
        end

        // glitch threshold: 2-cycle pulse ignored, 3-cycle reported
        do_reset();
        cfg_limit = 8'd6; cfg_thresh = 8'd3; cfg_mode = 2'b01;
        run(4'h0, 3); run(4'h1, 2); run(4'h0, 1);
        check("thr_2cyc", pulse_a, 0);
        run(4'h0, 2); run(4'h1, 3); run(4'h0, 1);
        check("thr_3cyc", pulse_a, 1);
        check("thr_cnt", cnt_a, 1);

        // clr coincident with four simultaneous violations
        do_reset();
        cfg_thresh = 8'd0;
        run(4'h0, 3); run(4'hF, 2); run(4'h0, 1);
        check("four_flag", flag_a, 4'hF);
        check("four_cnt", cnt_a, 4);
        run(4'h0, 1); run(4'hF, 2);
        clr = 1'b1;
        run(4'h0, 1);
        clr = 1'b0;
        check("clr_pulse", pulse_a, 4'hF);
        check("clr_flag", flag_a, 4'hF);
        check("clr_cnt", cnt_a, 4);

        // counter saturation and width saturation on the narrow instance
        do_reset();
        run(4'h0, 3);
        repeat (5) begin
            run(4'hF, 2); run(4'h0, 2);
        end
        check("sat_cnt_b", cnt_b, 15);
        check("sat_cnt_a", cnt_a, 20);
        cfg_limit = 8'd15;
        run(4'hF, 40); run(4'h0, 1);
        check("long_pulse_b", pulse_b, 0);
        check("long_pulse_a", pulse_a, 0);
        run(4'h0, 1); run(4'hF, 14); run(4'h0, 1);
        check("w14_pulse_b", pulse_b, 4'hF);

        // reset in mid-pulse abandons it; first level after reset unchecked
        do_reset();
        cfg_limit = 8'd6; cfg_mode = 2'b01;
        run(4'h0, 3); run(4'h1, 1);
        rst = 1'b1; clr = 1'b1;
        cycle();
        rst = 1'b0; clr = 1'b0;
        check("rst_flag", flag_a, 0);
        run(4'h1, 1); run(4'h0, 1);
        check("rst_pulse", pulse_a, 0);
        run(4'h0, 2); run(4'h1, 1);
        check("rst_cnt", cnt_a, 0);

        // mode none: widths still tracked, nothing reported
        cfg_mode = 2'b00;
        run(4'h0, 2); run(4'hF, 2); run(4'h0, 1);
        check("mode0_pulse", pulse_a, 0);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                cfg_limit  = 8'($urandom_range(0, 20));
                cfg_thresh = 8'($urandom_range(0, 6));
                cfg_mode   = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) sig_in[c] = ~sig_in[c];
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
